// File: rtl/demux_lane_sequencer.sv
// Purpose : serialises one 8-bit word per valid/ready handshake onto a 1-to-8 demux,
//           stepping the lane select so bit i lands on lane i.
// Latency : handshake at edge N drives lanes in cycles N+1..N+8 (all lane outputs registered).
// Backpr. : s_ready is high in IDLE, and also on the last lane when IDLE_GAP=0 (back-to-back words).
//           It is low in SEND and GAP, and for the first cycle out of reset.
// Ports   : clk, rst_n (async active-low); s_valid/s_ready/s_data upstream word;
//           dmx_in/dmx_sel/dmx_en demux drive; busy (SEND or GAP); word_done (last-lane pulse).
// Params  : MSB_FIRST (0: lanes 0->7, 1: lanes 7->0); IDLE_GAP (0..15 idle cycles after each word).
// Option  : `define DEMUX_SEQ_LANE_MASK_EN adds lane_mask[7:0]; only enabled lanes are visited.
module demux_lane_sequencer #(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
`ifdef DEMUX_SEQ_LANE_MASK_EN
    input  logic [7:0] lane_mask,
`endif
    output logic       dmx_in,
    output logic [2:0] dmx_sel,
    output logic       dmx_en,
    output logic       busy,
    output logic       word_done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [3:0] GAP_LEN = 4'(IDLE_GAP);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] word_q, word_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] gap_q, gap_d;
    logic       rdy_en_q;
    logic       dmx_in_q, dmx_in_d;
    logic [2:0] dmx_sel_q, dmx_sel_d;
    logic       dmx_en_q, dmx_en_d;
    logic       done_q, done_d;

    logic [7:0] mask_in;
    logic [3:0] nxt_q, nxt_d, first;
    logic       last, hs, empty_done;

`ifdef DEMUX_SEQ_LANE_MASK_EN
    assign mask_in = lane_mask;
`else
    assign mask_in = 8'hFF;
`endif

    // Map between visit-order position and lane index; the mapping is its own inverse.
    function automatic logic [2:0] lane_at(input logic [2:0] pos);
        if (MSB_FIRST != 0) return ~pos;
        else                return pos;
    endfunction

    // First enabled lane at visit position >= from_pos. Returns {found, lane}.
    function automatic logic [3:0] seek(input logic [7:0] mask, input logic [3:0] from_pos);
        logic [3:0] r;
        r = 4'b0;
        // Descending scan so the lowest qualifying position wins.
        for (int k = 7; k >= 0; k--) begin
            if (4'(k) >= from_pos && mask[lane_at(3'(k))]) r = {1'b1, lane_at(3'(k))};
        end
        return r;
    endfunction

    always_comb begin
        nxt_q = seek(mask_q, {1'b0, lane_at(idx_q)} + 4'd1);
        last  = !nxt_q[3];
        // Held low for the first cycle after reset release, independent of s_valid.
        s_ready = rdy_en_q && ((state_q == IDLE) ||
                               (state_q == SEND && last && IDLE_GAP == 0));
        hs    = s_valid && s_ready;
        first = seek(mask_in, 4'd0);

        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        mask_d     = mask_q;
        gap_d      = gap_q;
        empty_done = 1'b0;

        case (state_q)
            IDLE: ;
            SEND: begin
                if (!last) begin
                    idx_d = nxt_q[2:0];
                end else if (IDLE_GAP != 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LEN;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // A handshake (in IDLE or on the last lane) overrides the above.
        if (hs) begin
            word_d = s_data;
            mask_d = mask_in;
            if (first[3]) begin
                state_d = SEND;
                idx_d   = first[2:0];
            end else begin
                // Nothing to send: the word completes immediately.
                empty_done = 1'b1;
                state_d    = (IDLE_GAP != 0) ? GAP : IDLE;
                gap_d      = GAP_LEN;
            end
        end

        // Outputs are computed from next state so they appear registered.
        nxt_d     = seek(mask_d, {1'b0, lane_at(idx_d)} + 4'd1);
        dmx_en_d  = (state_d == SEND);
        dmx_sel_d = dmx_en_d ? idx_d : 3'b000;
        dmx_in_d  = dmx_en_d && word_d[idx_d];
        done_d    = (dmx_en_d && !nxt_d[3]) || empty_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'b000;
            word_q    <= 8'h00;
            mask_q    <= 8'h00;
            gap_q     <= 4'd0;
            rdy_en_q  <= 1'b0;
            dmx_in_q  <= 1'b0;
            dmx_sel_q <= 3'b000;
            dmx_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            gap_q     <= gap_d;
            rdy_en_q  <= 1'b1;
            dmx_in_q  <= dmx_in_d;
            dmx_sel_q <= dmx_sel_d;
            dmx_en_q  <= dmx_en_d;
            done_q    <= done_d;
        end
    end

    assign dmx_in    = dmx_in_q;
    assign dmx_sel   = dmx_sel_q;
    assign dmx_en    = dmx_en_q;
    assign word_done = done_q;
    assign busy      = (state_q != IDLE);

endmodule
